// File: rtl/led_seq_driver.sv
// led_seq_driver: accepts colour codes over valid/ready and shows each as a
// timed LED flash (ON_CYCLES lit, OFF_CYCLES dark), with all-on and dark codes.
`default_nettype none

module led_seq_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int CODE_WIDTH = 3,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  code_valid,
  input  logic [CODE_WIDTH-1:0] code_in,
  output logic                  code_ready,
  output logic [NUM_LEDS-1:0]   leds,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_LOAD =
    (OFF_CYCLES > 0) ? CNT_WIDTH'(OFF_CYCLES - 1) : '0;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_LEDS-1:0]   pattern;

  assign code_ready = (state_q == S_IDLE) & ~rst;
  assign leds       = leds_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // All-ones code lights every LED; codes between NUM_LEDS and all-ones are dark slots.
  always_comb begin
    pattern = '0;
    if (&code_in) begin
      pattern = '1;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        pattern[i] = (code_in == CODE_WIDTH'(i));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (code_valid && code_ready) begin
          state_d = S_ON;
          cnt_d   = ON_LOAD;
          leds_d  = pattern;
          busy_d  = 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          leds_d = '0;
          if (OFF_CYCLES > 0) begin
            state_d = S_OFF;
            cnt_d   = OFF_LOAD;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_OFF: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        leds_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_seq_driver.sv
// Directed bench for led_seq_driver: default instance plus an ON=1/OFF=0 instance.
`default_nettype none

module tb_led_seq_driver;

  logic       clk;
  logic       rst;
  logic       code_valid, code_valid2;
  logic [2:0] code_in, code_in2;
  logic       code_ready, code_ready2;
  logic [3:0] leds, leds2;
  logic       busy, busy2;
  logic       done, done2;

  int errors = 0;
  int checks = 0;

  led_seq_driver dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_in    (code_in),
    .code_ready (code_ready),
    .leds       (leds),
    .busy       (busy),
    .done       (done)
  );

  led_seq_driver #(
    .ON_CYCLES  (1),
    .OFF_CYCLES (0)
  ) dut_fast (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid2),
    .code_in    (code_in2),
    .code_ready (code_ready2),
    .leds       (leds2),
    .busy       (busy2),
    .done       (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one code on the default instance and check the full 7-cycle flash.
  task automatic run_code(input string tag, input logic [2:0] code,
                          input logic [3:0] exp_leds, input bit hold);
    code_valid = 1'b1;
    code_in    = code;
    step();
    if (!hold) code_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk({tag, "_leds"}, 32'(leds), (k <= 4) ? 32'(exp_leds) : 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h1);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_rdy"},  32'(code_ready), 32'h0);
      step();
    end
    chk({tag, "_done7"}, 32'(done), 32'h1);
    chk({tag, "_idle7"}, 32'(busy), 32'h0);
    chk({tag, "_rdy7"},  32'(code_ready), 32'h1);
    chk({tag, "_dark7"}, 32'(leds), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    code_valid  = 1'b0;
    code_in     = 3'd0;
    code_valid2 = 1'b0;
    code_in2    = 3'd0;
    step();
    step();
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdy",  32'(code_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(code_ready), 32'h1);

    // Single code 2, valid held for one cycle
    run_code("t1", 3'd2, 4'b0100, 1'b0);
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_idle_busy",  32'(busy), 32'h0);

    // Codes 0..3 streamed with valid held continuously
    run_code("t2a", 3'd0, 4'b0001, 1'b1);
    run_code("t2b", 3'd1, 4'b0010, 1'b1);
    run_code("t2c", 3'd2, 4'b0100, 1'b1);
    run_code("t2d", 3'd3, 4'b1000, 1'b0);
    step();

    // All-on code, then a dark slot
    run_code("t3_all",  3'd7, 4'b1111, 1'b0);
    step();
    run_code("t3_dark", 3'd5, 4'b0000, 1'b0);
    step();

    // Requests during ON are ignored and code_in is not resampled
    code_valid = 1'b1;
    code_in    = 3'd1;
    step();
    code_valid = 1'b0;
    chk("t4_leds1", 32'(leds), 32'h2);
    step();
    code_in    = 3'd3;
    code_valid = 1'b1;
    chk("t4_rdy_busy", 32'(code_ready), 32'h0);
    step();
    code_valid = 1'b0;
    chk("t4_leds3", 32'(leds), 32'h2);
    step();
    chk("t4_leds4", 32'(leds), 32'h2);
    for (int k = 5; k <= 6; k++) begin
      step();
      chk("t4_gap", 32'(leds), 32'h0);
    end
    step();
    chk("t4_done", 32'(done), 32'h1);
    step();
    chk("t4_no_requeue_busy", 32'(busy), 32'h0);
    chk("t4_no_requeue_leds", 32'(leds), 32'h0);

    // Reset on the 2nd ON cycle aborts the flash
    code_valid = 1'b1;
    code_in    = 3'd0;
    step();
    code_valid = 1'b0;
    chk("t5_on1", 32'(leds), 32'h1);
    step();
    chk("t5_on2", 32'(leds), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rdy_in_rst", 32'(code_ready), 32'h0);
    step();
    chk("t5_leds", 32'(leds), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_rdy_rst", 32'(code_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("t5_rdy_after", 32'(code_ready), 32'h1);
    step();
    chk("t5_no_done", 32'(done), 32'h0);
    chk("t5_still_dark", 32'(leds), 32'h0);

    // ON=1, OFF=0 instance: one accept every 2 cycles
    code_valid2 = 1'b1;
    code_in2    = 3'd3;
    step();
    chk("t6_leds_a", 32'(leds2), 32'h8);
    chk("t6_busy_a", 32'(busy2), 32'h1);
    chk("t6_rdy_a",  32'(code_ready2), 32'h0);
    step();
    chk("t6_done_a", 32'(done2), 32'h1);
    chk("t6_dark_a", 32'(leds2), 32'h0);
    chk("t6_rdy_b",  32'(code_ready2), 32'h1);
    code_in2 = 3'd1;
    step();
    chk("t6_leds_b", 32'(leds2), 32'h2);
    chk("t6_done_b0", 32'(done2), 32'h0);
    code_valid2 = 1'b0;
    step();
    chk("t6_done_b", 32'(done2), 32'h1);
    chk("t6_dark_b", 32'(leds2), 32'h0);
    step();
    chk("t6_idle", 32'(busy2), 32'h0);
    chk("t6_done_end", 32'(done2), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
